// File: rtl/line_buffer_bram.sv
// Multi-line video line buffer: NUM_LINES BRAM banks (registered read address),
// emits a vertical column of NUM_LINES taps one cycle after each accepted pixel.
module line_buffer_bram #(
  parameter int DATA_WIDTH = 8,
  parameter int LINE_WIDTH = 640,
  parameter int NUM_LINES  = 3,
  parameter int ADDR_WIDTH = (LINE_WIDTH > 1) ? $clog2(LINE_WIDTH) : 1,
  parameter int BANK_WIDTH = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1
) (
  input  logic                            clk,
  input  logic                            n_rst,
  input  logic                            in_valid,
  input  logic                            in_sof,
  input  logic [DATA_WIDTH-1:0]           in_data,
  output logic                            out_valid,
  output logic [NUM_LINES*DATA_WIDTH-1:0] out_data,
  output logic [NUM_LINES-1:0]            out_tap_valid,
  output logic [ADDR_WIDTH-1:0]           out_col,
  output logic                            out_sof,
  output logic                            out_eol
);

  localparam logic [ADDR_WIDTH-1:0] LAST_COL  = ADDR_WIDTH'(LINE_WIDTH - 1);
  localparam logic [BANK_WIDTH-1:0] LAST_BANK = BANK_WIDTH'(NUM_LINES - 1);

  logic [ADDR_WIDTH-1:0] col;
  logic [BANK_WIDTH-1:0] wr_bank;
  logic [BANK_WIDTH-1:0] lines_filled;

  logic                  accept;
  logic [ADDR_WIDTH-1:0] eff_col;
  logic [BANK_WIDTH-1:0] eff_bank;
  logic [BANK_WIDTH-1:0] eff_filled;
  logic [NUM_LINES-1:0]  tap_mask;

  logic [DATA_WIDTH-1:0] tap0_q;
  logic [BANK_WIDTH-1:0] bank_q;
  logic [DATA_WIDTH-1:0] rdata [NUM_LINES];

  // A start-of-frame pixel restarts at column 0 / bank 0 with no history.
  always_comb begin
    accept     = n_rst && in_valid;
    eff_col    = in_sof ? '0 : col;
    eff_bank   = in_sof ? '0 : wr_bank;
    eff_filled = in_sof ? '0 : lines_filled;
    tap_mask   = '0;
    for (int unsigned k = 0; k < NUM_LINES; k++) begin
      tap_mask[k] = (k <= 32'(eff_filled));
    end
  end

  for (genvar g = 0; g < NUM_LINES; g++) begin : g_bank
    logic [DATA_WIDTH-1:0] mem [LINE_WIDTH];
    logic [ADDR_WIDTH-1:0] raddr;

    always_ff @(posedge clk) begin
      if (accept && (eff_bank == BANK_WIDTH'(g))) begin
        mem[eff_col] <= in_data;
      end
      if (accept && (eff_bank != BANK_WIDTH'(g))) begin
        raddr <= eff_col;
      end
    end

    assign rdata[g] = mem[raddr];
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      col           <= '0;
      wr_bank       <= '0;
      lines_filled  <= '0;
      out_valid     <= 1'b0;
      tap0_q        <= '0;
      bank_q        <= '0;
      out_tap_valid <= '0;
      out_col       <= '0;
      out_sof       <= 1'b0;
      out_eol       <= 1'b0;
    end else if (in_valid) begin
      out_valid     <= 1'b1;
      tap0_q        <= in_data;
      bank_q        <= eff_bank;
      out_tap_valid <= tap_mask;
      out_col       <= eff_col;
      out_sof       <= in_sof;
      out_eol       <= (eff_col == LAST_COL);
      if (eff_col == LAST_COL) begin
        col          <= '0;
        wr_bank      <= (eff_bank == LAST_BANK) ? '0 : eff_bank + 1'b1;
        lines_filled <= (eff_filled == LAST_BANK) ? eff_filled : eff_filled + 1'b1;
      end else begin
        col          <= eff_col + 1'b1;
        wr_bank      <= eff_bank;
        lines_filled <= eff_filled;
      end
    end else begin
      out_valid <= 1'b0;
    end
  end

  // Tap k reads bank (bank_q - k) mod NUM_LINES; invalid taps are forced to zero.
  always_comb begin
    int unsigned idx;
    out_data = '0;
    idx      = 0;
    if (out_tap_valid[0]) begin
      out_data[0 +: DATA_WIDTH] = tap0_q;
    end
    for (int unsigned k = 1; k < NUM_LINES; k++) begin
      if (32'(bank_q) >= k) begin
        idx = 32'(bank_q) - k;
      end else begin
        idx = 32'(bank_q) + NUM_LINES - k;
      end
      if (out_tap_valid[k]) begin
        out_data[k*DATA_WIDTH +: DATA_WIDTH] = rdata[BANK_WIDTH'(idx)];
      end
    end
  end

endmodule

// File: tb/tb_line_buffer_bram.sv
// Directed self-checking bench for line_buffer_bram (8-bit, 4-pixel lines, 3 taps);
// pixel value encodes 16*line + column.
module tb_line_buffer_bram;

  logic        clk;
  logic        n_rst;
  logic        in_valid;
  logic        in_sof;
  logic [7:0]  in_data;
  logic        out_valid;
  logic [23:0] out_data;
  logic [2:0]  out_tap_valid;
  logic [1:0]  out_col;
  logic        out_sof;
  logic        out_eol;

  int unsigned errors;
  int unsigned checks;
  logic [23:0] last_data;

  line_buffer_bram #(
    .DATA_WIDTH(8),
    .LINE_WIDTH(4),
    .NUM_LINES (3)
  ) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .in_valid     (in_valid),
    .in_sof       (in_sof),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_tap_valid(out_tap_valid),
    .out_col      (out_col),
    .out_sof      (out_sof),
    .out_eol      (out_eol)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Accept one pixel and check the column it produces one cycle later.
  task automatic pix(input logic [7:0] d, input logic sof, input logic [1:0] col,
                     input logic [2:0] mask, input logic [7:0] t1, input logic [7:0] t2);
    in_valid = 1'b1;
    in_sof   = sof;
    in_data  = d;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    last_data = {t2, t1, d};
    chk("out_valid", 32'(out_valid), 32'd1);
    chk("tap0", 32'(out_data[7:0]), 32'(d));
    chk("tap1", 32'(out_data[15:8]), 32'(t1));
    chk("tap2", 32'(out_data[23:16]), 32'(t2));
    chk("tap_valid", 32'(out_tap_valid), 32'(mask));
    chk("out_col", 32'(out_col), 32'(col));
    chk("out_sof", 32'(out_sof), 32'(sof));
    chk("out_eol", 32'(out_eol), 32'(col == 2'd3));
  endtask

  // Stream columns c0..c1 of value-line vl; tap k expects line vl-k where enabled.
  task automatic line(input int vl, input logic sof, input logic [2:0] mask,
                      input int c0, input int c1);
    for (int c = c0; c <= c1; c++) begin
      pix(8'(16*vl + c), sof && (c == c0), 2'(c), mask,
          mask[1] ? 8'(16*(vl-1) + c) : 8'h00,
          mask[2] ? 8'(16*(vl-2) + c) : 8'h00);
    end
  endtask

  task automatic gap(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      chk("gap_valid", 32'(out_valid), 32'd0);
      chk("gap_hold", 32'(out_data), 32'(last_data));
    end
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    last_data = '0;
    n_rst     = 1'b0;
    in_valid  = 1'b1;
    in_sof    = 1'b0;
    in_data   = 8'h5a;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_mask", 32'(out_tap_valid), 32'd0);
    chk("rst_col", 32'(out_col), 32'd0);
    chk("rst_sof", 32'(out_sof), 32'd0);
    chk("rst_eol", 32'(out_eol), 32'd0);
    n_rst    = 1'b1;
    in_valid = 1'b0;

    // Frame fill: masks 001, 011, then 111; line 3 wraps into bank 0.
    line(0, 1'b1, 3'b001, 0, 3);
    line(1, 1'b0, 3'b011, 0, 3);
    line(2, 1'b0, 3'b111, 0, 3);
    line(3, 1'b0, 3'b111, 0, 3);

    // Gaps of 1 and 3 cycles inside line 4.
    line(4, 1'b0, 3'b111, 0, 0);
    gap(1);
    line(4, 1'b0, 3'b111, 1, 1);
    gap(3);
    line(4, 1'b0, 3'b111, 2, 3);

    // New frame, then a mid-line sof at column 2 of its line 1.
    line(6, 1'b1, 3'b001, 0, 3);
    line(7, 1'b0, 3'b011, 0, 1);
    pix(8'h80, 1'b1, 2'd0, 3'b001, 8'h00, 8'h00);
    line(8, 1'b0, 3'b001, 1, 3);
    line(9, 1'b0, 3'b011, 0, 3);
    line(10, 1'b0, 3'b111, 0, 1);

    // One-cycle reset mid-line with in_valid held high.
    n_rst    = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'haa;
    @(posedge clk);
    #1;
    n_rst    = 1'b1;
    in_valid = 1'b0;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_data", 32'(out_data), 32'd0);
    line(11, 1'b0, 3'b001, 0, 3);
    line(12, 1'b0, 3'b011, 0, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/line_buffer_bram.md
Name: line_buffer_bram

Overview:
Multi-line video line buffer for the VDMA pixel path, built from NUM_LINES banks of inferred block RAM. Each bank uses the team's registered-read-address single-clock BRAM style. It accepts one pixel per valid cycle in raster order. For every input pixel it emits a vertical column of NUM_LINES taps: the current pixel plus the pixels at the same column in the previous NUM_LINES-1 lines. It feeds downstream 2-D window filters and sits between the stream input and the filter kernels.

Parameters:
DATA_WIDTH, 8, bits per pixel.
LINE_WIDTH, 640, pixels per line (>=2); line length is fixed, with no end-of-line input.
NUM_LINES, 3, number of output taps and number of BRAM banks (>=2).
ADDR_WIDTH, log2(LINE_WIDTH), column/address width; computed by a log2 function, ceil semantics.
BANK_WIDTH, log2(NUM_LINES), bank-pointer width (min 1).

Ports:
clk  in  1  system clock; all logic on posedge.
n_rst  in  1  reset, synchronous, active-low.
in_valid  in  1  pixel strobe; no backpressure.
in_sof  in  1  start of frame, qualified by in_valid.
in_data  in  DATA_WIDTH  input pixel.
out_valid  out  1  output column valid.
out_data  out  NUM_LINES*DATA_WIDTH  tap k in bits [k*DATA_WIDTH +: DATA_WIDTH]; tap0 = current line, tap k = k lines above.
out_tap_valid  out  NUM_LINES  bit k=1 when tap k holds real data.
out_col  out  ADDR_WIDTH  column of the output pixel.
out_sof  out  1  in_sof delayed with the data.
out_eol  out  1  high when out_col==LINE_WIDTH-1.

Behaviour:
- Reset (n_rst low at posedge):
  - col=0, wr_bank=0, lines_filled=0.
  - out_valid=0, out_data=0, out_tap_valid=0, out_col=0, out_sof=0, out_eol=0.
  - BRAM contents are not cleared.
  - Reset overrides in_valid in the same cycle.
- Accept: a pixel is accepted on a posedge with n_rst=1 and in_valid=1. While in_valid=0, all state and outputs hold, except out_valid, which drops to 0.
- Effective column/bank for an accepted pixel:
  - If in_sof=1: column 0, bank 0, lines_filled treated as 0; the pixel is written normally.
  - Otherwise: the current col, wr_bank and lines_filled.
- Memory access on accept:
  - Write in_data to bank wr_bank at address col.
  - For k=1..NUM_LINES-1, present address col to bank (wr_bank-k) mod NUM_LINES; each bank's read address register updates only when enabled.
  - The written bank is never read in the same cycle, so there is no read/write collision.
- Latency: exactly 1 cycle. Pixel accepted at posedge t appears at posedge t+1 with:
  - out_valid=1, tap0=in_data (registered), tap k = stored pixel from bank (wr_bank-k) mod NUM_LINES at column col.
  - out_col=col, out_sof=in_sof, out_eol=(col==LINE_WIDTH-1).
  - out_tap_valid bit k = (k <= lines_filled).
  - Taps whose valid bit is 0 are driven to 0.
  - The tap-to-bank mapping uses a registered copy of wr_bank so it matches the read.
- Counters after accept:
  - If col==LINE_WIDTH-1: col wraps to 0, wr_bank increments mod NUM_LINES (NUM_LINES-1 wraps to 0), lines_filled increments and saturates at NUM_LINES-1.
  - Otherwise col increments by 1.
- in_sof mid-line abandons the partial line: old data in other banks is ignored via lines_filled=0.
- Reset mid-line: the next accepted pixel is column 0, bank 0, tap mask 1.
- out_data holds its last value while out_valid=0.
- Non-power-of-2 LINE_WIDTH and NUM_LINES are supported via explicit compare-and-wrap, never via modulo by bit truncation.

Test Plan:
Config for 1–4, 6: DATA_WIDTH=8, LINE_WIDTH=4, NUM_LINES=3; pixel value = 16*line+col.
1. After reset, stream line 0 continuously with in_sof on the first pixel. Required: out_valid one cycle after each accept; tap0=0x00..0x03; out_tap_valid=3'b001; taps 1/2 = 0; out_sof on col 0; out_eol on col 3.
2. Stream lines 1 and 2. Required at line 2 col 1: tap0=0x21, tap1=0x11, tap2=0x01, out_tap_valid=3'b111. Required during line 1: mask 3'b011.
3. Line 3 (bank wrap: writes bank 0). Required at col 2: tap0=0x32, tap1=0x22, tap2=0x12; mask stays 3'b111 (lines_filled saturated at 2).
4. Insert in_valid=0 gaps of 1 and 3 cycles inside a line. Required: out_valid=0 during gaps; out_col continues without skip; tap values are identical to the gap-free run.
5. Mid-frame, assert in_sof with a pixel at col 2 of line 1, then stream. Required: that pixel is output with out_col=0 and out_tap_valid=3'b001. The next full line is output with mask 3'b011, and its tap1 equals the new frame's line 0.
6. Pull n_rst low for one cycle while in_valid=1 mid-line. Required: the next cycle has out_valid=0 and out_data=0. The next accepted pixel has out_col=0 and mask 3'b001.
